// File: rtl/tmds_symbol_pipeline.sv
// TMDS symbol generator: N data lanes plus clock-lane word, 3-stage pipeline,
// with a built-in colour-bar source and sync polarity correction.

// One TMDS lane: S0 input register, S1 transition minimisation, S2 DC balance.
module tmds_lane (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] d,
  input  logic       de,
  input  logic       c0,
  input  logic       c1,
  output logic [9:0] sym
);
  localparam logic [9:0] CTL_00 = 10'b1101010100;
  localparam logic [9:0] CTL_01 = 10'b0010101011;
  localparam logic [9:0] CTL_10 = 10'b0101010100;
  localparam logic [9:0] CTL_11 = 10'b1010101011;

  typedef struct packed { logic [7:0] d;  logic de; logic c0; logic c1; } lane_req_t;
  typedef struct packed { logic [8:0] qm; logic de; logic c0; logic c1; } lane_qm_t;

  lane_req_t         s0_q;
  lane_qm_t          s1_q;
  logic [3:0]        n1_d, n1_q;
  logic [8:0]        qm;
  logic signed [4:0] n1s, n0s, cnt_q, cnt_d;
  logic [9:0]        sym_d;

  // S0: capture pixel byte and controls
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) s0_q <= '0;
    else        s0_q <= {d, de, c0, c1};

  // S1 comb: XOR/XNOR chain chosen to minimise transitions
  always_comb begin
    n1_d = '0;
    for (int i = 0; i < 8; i++) n1_d = n1_d + {3'b0, s0_q.d[i]};
    qm    = '0;
    qm[0] = s0_q.d[0];
    if (n1_d > 4'd4 || (n1_d == 4'd4 && !s0_q.d[0])) begin
      for (int i = 1; i < 8; i++) qm[i] = ~(qm[i-1] ^ s0_q.d[i]);
      qm[8] = 1'b0;
    end else begin
      for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ s0_q.d[i];
      qm[8] = 1'b1;
    end
  end

  // S1: register q_m with de/controls delayed alongside
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) s1_q <= '0;
    else        s1_q <= {qm, s0_q.de, s0_q.c0, s0_q.c1};

  // S2 comb: pick inversion from running disparity; blanking clears disparity
  always_comb begin
    n1_q = '0;
    for (int i = 0; i < 8; i++) n1_q = n1_q + {3'b0, s1_q.qm[i]};
    n1s   = {1'b0, n1_q};
    n0s   = 5'sd8 - n1s;
    sym_d = CTL_00;
    cnt_d = cnt_q;
    if (!s1_q.de) begin
      cnt_d = '0;
      case ({s1_q.c1, s1_q.c0})
        2'b00:   sym_d = CTL_00;
        2'b01:   sym_d = CTL_01;
        2'b10:   sym_d = CTL_10;
        default: sym_d = CTL_11;
      endcase
    end else if (cnt_q == 5'sd0 || n1s == n0s) begin
      sym_d = {~s1_q.qm[8], s1_q.qm[8], s1_q.qm[8] ? s1_q.qm[7:0] : ~s1_q.qm[7:0]};
      cnt_d = s1_q.qm[8] ? cnt_q + n1s - n0s : cnt_q + n0s - n1s;
    end else if ((cnt_q > 5'sd0 && n1s > n0s) || (cnt_q < 5'sd0 && n0s > n1s)) begin
      sym_d = {1'b1, s1_q.qm[8], ~s1_q.qm[7:0]};
      cnt_d = cnt_q + (s1_q.qm[8] ? 5'sd2 : 5'sd0) + n0s - n1s;
    end else begin
      sym_d = {1'b0, s1_q.qm[8], s1_q.qm[7:0]};
      cnt_d = cnt_q + n1s - n0s - (s1_q.qm[8] ? 5'sd0 : 5'sd2);
    end
  end

  // S2: output symbol and disparity counter
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sym   <= CTL_00;
      cnt_q <= '0;
    end else begin
      sym   <= sym_d;
      cnt_q <= cnt_d;
    end
endmodule

module tmds_symbol_pipeline #(
  parameter int CH_NUM = 3,
  parameter bit HS_INV = 1'b0,
  parameter bit VS_INV = 1'b0,
  parameter int BAR_W  = 80
) (
  input  logic                  p_clk,
  input  logic                  arstn,
  input  logic [8*CH_NUM-1:0]   VGA_data,
  input  logic                  VGA_hs,
  input  logic                  VGA_vs,
  input  logic                  VGA_de,
  input  logic                  pattern_en,
  output logic [10*CH_NUM-1:0]  tmds_data,
  output logic [9:0]            tmds_clk_word,
  output logic                  sym_valid
);
  localparam int STAGES = 2;
  localparam int BCW    = (BAR_W > 1) ? $clog2(BAR_W) : 1;

  logic [1:0]               rst_sync;
  logic                     rst_n;
  logic                     hs_c, vs_c, vs_d, vs_rise, pat_act, pat_on;
  logic [BCW-1:0]           bar_cnt;
  logic [2:0]               bar_idx;
  logic [23:0]              bar_rgb;
  logic [STAGES:0]          vld_pipe;
  logic [CH_NUM-1:0][7:0]   vga_in, pix;
  logic [CH_NUM-1:0]        c0_bus, c1_bus;
  logic [CH_NUM-1:0][9:0]   sym_bus;

  // Reset: immediate assertion, release aligned to p_clk after two flops
  always_ff @(posedge p_clk or negedge arstn)
    if (!arstn) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};

  assign rst_n   = rst_sync[1];
  assign hs_c    = VGA_hs ^ HS_INV;
  assign vs_c    = VGA_vs ^ VS_INV;
  assign vs_rise = vs_c & ~vs_d;
  // A vsync rise switches the pattern for the very pixel on that cycle
  assign pat_on  = vs_rise ? pattern_en : pat_act;

  // Pattern request is only latched at frame start
  always_ff @(posedge p_clk or negedge rst_n)
    if (!rst_n) begin
      vs_d    <= 1'b0;
      pat_act <= 1'b0;
    end else begin
      vs_d <= vs_c;
      if (vs_rise) pat_act <= pattern_en;
    end

  // Bar position: restart on blanking, advance every BAR_W active pixels, hold at black
  always_ff @(posedge p_clk or negedge rst_n)
    if (!rst_n) begin
      bar_cnt <= '0;
      bar_idx <= '0;
    end else if (!VGA_de) begin
      bar_cnt <= '0;
      bar_idx <= '0;
    end else if (bar_cnt == BCW'(BAR_W - 1)) begin
      bar_cnt <= '0;
      if (bar_idx != 3'd7) bar_idx <= bar_idx + 3'd1;
    end else begin
      bar_cnt <= bar_cnt + 1'b1;
    end

  // Bar colour as {R,G,B}
  always_comb
    case (bar_idx)
      3'd0:    bar_rgb = 24'hFFFFFF;
      3'd1:    bar_rgb = 24'hFFFF00;
      3'd2:    bar_rgb = 24'h00FFFF;
      3'd3:    bar_rgb = 24'h00FF00;
      3'd4:    bar_rgb = 24'hFF00FF;
      3'd5:    bar_rgb = 24'hFF0000;
      3'd6:    bar_rgb = 24'h0000FF;
      default: bar_rgb = 24'h000000;
    endcase

  assign vga_in = VGA_data;

  // Per-lane source select; only the blue lane of each pixel carries syncs
  always_comb
    for (int i = 0; i < CH_NUM; i++) begin
      pix[i]    = (pat_on && VGA_de) ? bar_rgb[8*(i%3) +: 8] : vga_in[i];
      c0_bus[i] = (i % 3 == 0) ? hs_c : 1'b0;
      c1_bus[i] = (i % 3 == 0) ? vs_c : 1'b0;
    end

  tmds_lane u_lane [CH_NUM-1:0] (
    .clk   (p_clk),
    .rst_n (rst_n),
    .d     (pix),
    .de    (VGA_de),
    .c0    (c0_bus),
    .c1    (c1_bus),
    .sym   (sym_bus)
  );

  // Valid follows the data through the three stages
  always_ff @(posedge p_clk or negedge rst_n)
    if (!rst_n) vld_pipe <= '0;
    else        vld_pipe <= {vld_pipe[STAGES-1:0], 1'b1};

  assign sym_valid     = vld_pipe[STAGES];
  assign tmds_data     = sym_bus;
  assign tmds_clk_word = 10'b1111100000;
endmodule

// File: tb/tb_tmds_symbol_pipeline.sv
// Scoreboard bench: dual-link instance checked against a reference encoder,
// plus a single-link instance with inverted sync polarity.
module tb_tmds_symbol_pipeline;
  localparam int CH = 6;
  localparam int BW = 2;

  logic                p_clk = 1'b0;
  logic                arstn;
  logic [8*CH-1:0]     vga_data;
  logic                hs, vs, de, pat_en;
  logic [10*CH-1:0]    tmds_data;
  logic [9:0]          clk_word;
  logic                sym_valid;
  logic [29:0]         p_data;
  logic [9:0]          p_clk_word;
  logic                p_valid;

  tmds_symbol_pipeline #(.CH_NUM(CH), .HS_INV(1'b0), .VS_INV(1'b0), .BAR_W(BW)) dut (
    .p_clk(p_clk), .arstn(arstn), .VGA_data(vga_data), .VGA_hs(hs), .VGA_vs(vs),
    .VGA_de(de), .pattern_en(pat_en), .tmds_data(tmds_data), .tmds_clk_word(clk_word),
    .sym_valid(sym_valid));

  tmds_symbol_pipeline #(.CH_NUM(3), .HS_INV(1'b1), .VS_INV(1'b1), .BAR_W(80)) dut_p (
    .p_clk(p_clk), .arstn(arstn), .VGA_data(vga_data[23:0]), .VGA_hs(hs), .VGA_vs(vs),
    .VGA_de(de), .pattern_en(1'b0), .tmds_data(p_data), .tmds_clk_word(p_clk_word),
    .sym_valid(p_valid));

  always #5 p_clk = ~p_clk;

  typedef struct { int due; logic [10*CH-1:0] sym; logic vld; } exp_t;
  exp_t sb[$];

  logic [23:0] bar_tab [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                               24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
  logic [9:0]  ctl_tab [4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};

  int    n_cmp = 0, n_err = 0;
  int    ecnt = 0, rel_edge = 0, m_rel = 0;
  int    m_cnt [CH];
  int    m_bc, m_idx;
  logic  m_vsd, m_pat, push_en, seen_vld;
  string phase;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference TMDS encoder (both stages), one symbol per call
  task automatic tmds_enc(input logic [7:0] d, input logic den, input logic c0, input logic c1,
                          input int ci, output logic [9:0] s, output int co);
    int n1, n1q, n0q, q8;
    logic use_xnor;
    logic [8:0] qm;
    n1 = $countones(d);
    use_xnor = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
    qm[0] = d[0];
    for (int i = 1; i < 8; i++) qm[i] = use_xnor ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
    qm[8] = ~use_xnor;
    q8  = qm[8] ? 1 : 0;
    n1q = $countones(qm[7:0]);
    n0q = 8 - n1q;
    if (!den) begin
      s  = ctl_tab[{c1, c0}];
      co = 0;
    end else if (ci == 0 || n1q == n0q) begin
      s  = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
      co = q8 ? ci + n1q - n0q : ci + n0q - n1q;
    end else if ((ci > 0 && n1q > n0q) || (ci < 0 && n0q > n1q)) begin
      s  = {1'b1, qm[8], ~qm[7:0]};
      co = ci + 2 * q8 + n0q - n1q;
    end else begin
      s  = {1'b0, qm[8], qm[7:0]};
      co = ci + n1q - n0q - 2 * (1 - q8);
    end
  endtask

  task automatic model_clear();
    for (int l = 0; l < CH; l++) m_cnt[l] = 0;
    m_bc = 0; m_idx = 0; m_vsd = 1'b0; m_pat = 1'b0;
  endtask

  // Called at each rising edge with the inputs the DUT just sampled
  task automatic model_step();
    exp_t e;
    logic [23:0] col;
    logic [7:0]  b;
    logic [9:0]  s;
    int co;
    if (!arstn) begin
      model_clear();
      return;
    end
    e.due = ecnt + 2;
    if (m_rel < 2) begin
      m_rel++;
      e.vld = 1'b0;
      for (int l = 0; l < CH; l++) e.sym[10*l +: 10] = 10'h354;
      if (push_en) sb.push_back(e);
      return;
    end
    if (vs && !m_vsd) m_pat = pat_en;
    m_vsd = vs;
    col = bar_tab[m_idx];
    e.vld = 1'b1;
    for (int l = 0; l < CH; l++) begin
      b = (m_pat && de) ? col[8*(l%3) +: 8] : vga_data[8*l +: 8];
      tmds_enc(b, de, (l % 3 == 0) ? hs : 1'b0, (l % 3 == 0) ? vs : 1'b0, m_cnt[l], s, co);
      m_cnt[l] = co;
      e.sym[10*l +: 10] = s;
    end
    if (!de) begin
      m_bc = 0; m_idx = 0;
    end else if (m_bc == BW - 1) begin
      m_bc = 0;
      if (m_idx < 7) m_idx++;
    end else begin
      m_bc++;
    end
    if (push_en) sb.push_back(e);
  endtask

  // One clock: model at the edge, compare due output at the following negedge
  task automatic cyc();
    exp_t e;
    @(posedge p_clk);
    ecnt++;
    model_step();
    @(negedge p_clk);
    if (sb.size() > 0 && sb[0].due == ecnt) begin
      e = sb.pop_front();
      chk($sformatf("%s vld", phase), sym_valid, e.vld);
      chk($sformatf("%s clkw", phase), clk_word, 10'h3E0);
      for (int l = 0; l < CH; l++)
        chk($sformatf("%s lane%0d @%0d", phase, l, ecnt), tmds_data[10*l +: 10], e.sym[10*l +: 10]);
    end
    if (sym_valid && !seen_vld) begin
      seen_vld = 1'b1;
      chk("vld_rise_edges", ecnt - rel_edge, 5);
    end
  endtask

  task automatic rand_in();
    vga_data[31:0]  = $urandom();
    vga_data[47:32] = 16'($urandom());
  endtask

  task automatic chk_reset(input string tag);
    for (int l = 0; l < CH; l++) chk($sformatf("%s rst lane%0d", tag, l), tmds_data[10*l +: 10], 10'h354);
    for (int l = 0; l < 3; l++)  chk($sformatf("%s rst p_lane%0d", tag, l), p_data[10*l +: 10], 10'h354);
    chk($sformatf("%s rst clkw", tag), clk_word, 10'h3E0);
    chk($sformatf("%s rst vld", tag), sym_valid, 1'b0);
    chk($sformatf("%s rst p_vld", tag), p_valid, 1'b0);
  endtask

  task automatic release_rst();
    arstn = 1'b1;
    m_rel = 0;
    rel_edge = ecnt;
    seen_vld = 1'b0;
  endtask

  task automatic idle(input int n);
    de = 1'b0;
    for (int i = 0; i < n; i++) begin rand_in(); cyc(); end
  endtask

  initial begin
    arstn = 1'b0; de = 1'b0; hs = 1'b0; vs = 1'b0; pat_en = 1'b0;
    vga_data = '0; push_en = 1'b1; seen_vld = 1'b0; phase = "reset";
    model_clear();
    @(negedge p_clk);
    for (int i = 0; i < 4; i++) begin
      rand_in(); de = 1'($urandom_range(0, 1)); hs = 1'($urandom_range(0, 1));
      vs = 1'($urandom_range(0, 1)); cyc();
    end
    chk_reset("init");
    hs = 1'b0; vs = 1'b0;
    release_rst();
    idle(4);

    // Control symbols on every {vs,hs}; inverted instance shows the complement code
    phase = "ctrl";
    for (int v = 0; v < 4; v++) begin
      logic [1:0] pv;
      pv = 2'(v);
      {vs, hs} = pv;
      idle(3);
      chk($sformatf("pol_l0 v%0d", v), p_data[9:0], ctl_tab[~pv]);
      chk($sformatf("pol_l1 v%0d", v), p_data[19:10], 10'h354);
    end
    hs = 1'b0; vs = 1'b0;

    // Disparity from blanking: three zero bytes, then one 0xFF
    phase = "disp";
    idle(2);
    de = 1'b1; vga_data = '0;
    repeat (3) cyc();
    idle(2);
    de = 1'b1; vga_data = '1;
    cyc();
    idle(2);

    // Pattern: request mid-frame is ignored until the next vsync rise
    phase = "pat";
    vs = 1'b1; idle(1);
    de = 1'b1;
    for (int i = 0; i < 4; i++) begin rand_in(); if (i == 1) pat_en = 1'b1; cyc(); end
    vs = 1'b0; idle(2);
    vs = 1'b1; idle(1);
    de = 1'b1;
    for (int i = 0; i < 22; i++) begin rand_in(); cyc(); end
    idle(2);
    pat_en = 1'b0; de = 1'b1;
    for (int i = 0; i < 4; i++) begin rand_in(); cyc(); end
    vs = 1'b0; idle(2);
    vs = 1'b1; de = 1'b1;
    for (int i = 0; i < 4; i++) begin rand_in(); cyc(); end
    vs = 1'b0; idle(2);
    vs = 1'b1; pat_en = 1'b1; de = 1'b1;
    for (int i = 0; i < 6; i++) begin rand_in(); cyc(); end

    // Dual-link random traffic with occasional blanking and frame starts
    phase = "rand";
    for (int i = 0; i < 300; i++) begin
      rand_in();
      de = ($urandom_range(0, 9) != 0);
      hs = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 19) == 0) vs = ~vs;
      pat_en = 1'($urandom_range(0, 1));
      cyc();
    end

    // Reset in the middle of an active line
    phase = "midrst";
    de = 1'b1;
    for (int i = 0; i < 5; i++) begin rand_in(); cyc(); end
    arstn = 1'b0;
    #1;
    sb.delete();
    model_clear();
    chk_reset("mid_now");
    for (int i = 0; i < 3; i++) begin rand_in(); cyc(); end
    chk_reset("mid_hold");
    release_rst();
    for (int i = 0; i < 40; i++) begin
      rand_in(); de = ($urandom_range(0, 5) != 0); hs = 1'($urandom_range(0, 1)); cyc();
    end

    push_en = 1'b0;
    idle(3);
    chk("sb_drain", sb.size(), 0);
    chk("vld_seen", seen_vld, 1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/tmds_symbol_pipeline.md
# tmds_symbol_pipeline

Parametrised, single-clock TMDS symbol generator for N lanes. It converts VGA-style pixel/sync/DE input into 10-bit DC-balanced TMDS symbols per lane, plus the clock-lane word, through a fixed 3-stage pipeline. Built-in colour-bar pattern generator and sync-polarity options are included. It sits between the video timing source and the per-lane 10:1 serialisers, which run in their own domain and are outside this block.

## Interface
- CH_NUM, 3: number of TMDS data lanes; must be a multiple of 3. Each group of 3 is one pixel: lane 3k = blue, 3k+1 = green, 3k+2 = red. 6 = dual-link.
- HS_INV, 0: 1 inverts VGA_hs before encoding.
- VS_INV, 0: 1 inverts VGA_vs before encoding.
- BAR_W, 80: colour-bar width in p_clk cycles, at least 1.

Ports:
- p_clk  in  1  pixel clock; all logic is on its rising edge.
- arstn  in  1  asynchronous active-low reset. Assertion acts immediately; deassertion passes through an internal 2-flop synchroniser.
- VGA_data  in  8*CH_NUM  pixel bytes; lane i uses bits [8i+7:8i].
- VGA_hs  in  1  horizontal sync.
- VGA_vs  in  1  vertical sync.
- VGA_de  in  1  data enable, active high.
- pattern_en  in  1  request colour-bar pattern instead of VGA_data.
- tmds_data  out  10*CH_NUM  symbols; lane i uses bits [10i+9:10i]; bit 0 is transmitted first.
- tmds_clk_word  out  10  clock-lane word.
- sym_valid  out  1  high when tmds_data carries pipelined input.

## Operation
- **S0 (input register):** captures data, de, c0 and c1 per lane.
  - Lanes 3k get c0 = VGA_hs^HS_INV and c1 = VGA_vs^VS_INV.
  - All other lanes get c0 = c1 = 0.
  - If the pattern is active and de = 1, the data is replaced by the bar colour.
- **S1 (transition minimisation):** N1 = number of ones in d.
  - If N1>4, or N1==4 with d[0]==0: q_m[0]=d[0], q_m[i]=q_m[i-1] XNOR d[i], q_m[8]=0.
  - Otherwise: use XOR and set q_m[8]=1.
  - de, c0 and c1 are delayed alongside.
- **S2 (DC balance):** per-lane signed 5-bit disparity counter cnt. N1/N0 here count ones/zeros in q_m[7:0].
  - **de=0:** emit the control symbol and set cnt=0.
    - {c1,c0}=00 → 10'b1101010100
    - {c1,c0}=01 → 10'b0010101011
    - {c1,c0}=10 → 10'b0101010100
    - {c1,c0}=11 → 10'b1010101011
  - **cnt==0 or N1==N0:** out = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]}.
    - If q_m[8] is set: cnt += N1−N0.
    - Otherwise: cnt += N0−N1.
  - **(cnt>0 and N1>N0) or (cnt<0 and N0>N1):** out = {1, q_m[8], ~q_m[7:0]}; cnt += 2·q_m[8] + N0−N1.
  - **Otherwise:** out = {0, q_m[8], q_m[7:0]}; cnt += N1−N0 − 2·(~q_m[8]).
- **Pattern generator:**
  - `pattern_en` is sampled only on the rising edge of the polarity-corrected vsync. A mid-frame change has no effect until the next frame.
  - Bar counter and bar index reset to 0 on every cycle with de=0.
  - During de=1 the counter counts 0..BAR_W−1. On wrap, the index advances 0..7 and saturates at 7.
  - Bar colours, index 0..7, as {R,G,B}: white FFFFFF, yellow FFFF00, cyan 00FFFF, green 00FF00, magenta FF00FF, red FF0000, blue 0000FF, black 000000.
  - All pixel groups show the same colour.
- tmds_clk_word is constant 10'b1111100000 after reset.

## Timing
- **Latency:** inputs sampled at edge k appear on tmds_data after edge k+2.
- **Reset (arstn low):**
  - every tmds_data lane = 10'b1101010100;
  - tmds_clk_word = 10'b1111100000;
  - sym_valid = 0;
  - all cnt = 0;
  - pattern inactive, counters 0.
- **Reset release:** the synchronised reset drops on the 2nd p_clk edge after arstn rises. sym_valid goes high 3 edges later and stays high.
- **Reset mid-line:** all state is cleared immediately. No partial symbol is held.
- **de edges:** the first data symbol after blanking always starts from cnt=0. The transition takes effect with the same 3-stage latency as the data.
- **vsync edge and de=1 on the same cycle:** the pattern switch applies to that cycle's pixel.

## Test plan
- **Reset:** hold arstn low with random inputs → all lanes 0x354, clock word 0x3E0, sym_valid 0. Release → sym_valid rises exactly 5 edges after arstn rises.
- **Control symbols:** de=0, CH_NUM=3, cycle {vs,hs} 00/01/10/11 → lane0 shows 0x354/0x0AB/0x154/0x2AB after 3 edges; lanes 1 and 2 stay 0x354.
- **Disparity:** from blanking, drive de=1 with data 0x00 on 3 cycles → lane outputs 0x100, 0x3FF, 0x100. Data 0xFF from cnt=0 → 0x200.
- **Polarity:** HS_INV=1, VS_INV=1, hs=vs=0, de=0 → lane0 shows 0x2AB.
- **Pattern:** BAR_W=2, set pattern_en mid-frame → no change until the next vsync rise. Then de=1 for 18 cycles → red lane shows encoded FF,FF,FF,FF,00,00,00,00,FF,FF,FF,FF,00… Index saturates at black.
- **Dual link:** CH_NUM=6 with random data, checked against a reference encoder model → each lane has an independent cnt. Across a long de=1 burst, every lane's |cnt| stays ≤ 8.
